io_port_unit: RTL and testbench

//  Peripheral-side I/O port block hung on the CPU's port bus (IOAD/IODB/nPREQ/nPRD/nPWR).

---
 rtl/io_port_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_io_port_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_unit.sv
// CPU port-bus peripheral: LED latch / synchronized switches, TX and RX byte FIFOs, status and
// sticky error flags. Define IO_IRQ_EN to add the registered active-low nIRQ output.
module io_port_unit #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] IOAD,
    inout  wire  [7:0] IODB,
    input  logic       nPREQ,
    input  logic       nPRD,
    input  logic       nPWR,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
`ifdef IO_IRQ_EN
    output logic       nIRQ,
`endif
    output logic       rx_ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Strobe decode and edge detection
    logic       wr_act, rd_act;
    logic       wr_pulse, rd_rise, rd_fall;
    logic       wr_act_q, wr_act_d;
    logic       rd_act_q, rd_act_d;
    logic       rd_arm_q, rd_arm_d;
    logic [1:0] rd_addr_q, rd_addr_d;

    assign wr_act   = !nPREQ && !nPWR;
    assign rd_act   = !nPREQ && !nPRD;
    assign wr_pulse = wr_act && !wr_act_q;
    assign rd_rise  = rd_act && !rd_act_q;
    // Only a strobe whose start was seen after reset may trigger the end-of-read pop.
    assign rd_fall  = !rd_act && rd_act_q && rd_arm_q;

    always_comb begin
        wr_act_d  = wr_act;
        rd_act_d  = rd_act;
        rd_arm_d  = rd_arm_q;
        rd_addr_d = rd_addr_q;
        if (rd_rise) begin
            rd_arm_d  = 1'b1;
            rd_addr_d = IOAD;
        end else if (!rd_act) begin
            rd_arm_d = 1'b0;
        end
    end

    logic wr_port0, wr_port1, wr_port3, rd_pop_req;

    assign wr_port0   = wr_pulse && (IOAD == 2'd0);
    assign wr_port1   = wr_pulse && (IOAD == 2'd1);
    assign wr_port3   = wr_pulse && (IOAD == 2'd3);
    assign rd_pop_req = rd_fall && (rd_addr_q == 2'd1);

    // Switch synchronizer
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = sw_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // LED latch
    logic [7:0] led_q, led_d;

    always_comb begin
        led_d = led_q;
        if (wr_port0) begin
            led_d = IODB;
        end
    end

    assign led_out = led_q;

    // TX FIFO
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = wr_port1 && !tx_full;
    assign tx_pop   = !tx_empty && tx_ready;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];

    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_ptr_q] = IODB;
            tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // RX FIFO
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = rd_pop_req && !rx_empty;
    assign rx_ready = !rx_full;

    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_ptr_q] = rx_data;
            rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // Sticky flags: clear first, so a same-cycle set wins
    logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d, rx_ovf_q, rx_ovf_d;

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        rx_ovf_d = rx_ovf_q;
        if (wr_port3) begin
            if (IODB[0]) tx_ovf_d = 1'b0;
            if (IODB[1]) rx_udf_d = 1'b0;
            if (IODB[2]) rx_ovf_d = 1'b0;
        end
        if (wr_port1 && tx_full)     tx_ovf_d = 1'b1;
        if (rd_pop_req && rx_empty)  rx_udf_d = 1'b1;
        if (rx_valid && rx_full)     rx_ovf_d = 1'b1;
    end

    logic irq_bit;

`ifdef IO_IRQ_EN
    logic irq_n_q, irq_n_d;

    assign irq_n_d = !(!rx_empty || tx_ovf_q || rx_ovf_q);
    assign nIRQ    = irq_n_q;
    assign irq_bit = !irq_n_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= irq_n_d;
        end
    end
`else
    assign irq_bit = 1'b0;
`endif

    // Read mux, driven onto the bus only while the read strobe is active
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = 8'h00;
        case (IOAD)
            2'd0:    rd_mux = sync_q[SYNC_STAGES-1];
            2'd1:    rd_mux = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
            2'd2:    rd_mux = {irq_bit, 3'b000, rx_full, rx_empty, tx_full, tx_empty};
            default: rd_mux = {5'b00000, rx_ovf_q, rx_udf_q, tx_ovf_q};
        endcase
    end

    assign IODB = rd_act ? rd_mux : 8'bz;

    // Reset forces the strobe history "active" so a strobe held through reset is not an edge.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_act_q    <= 1'b1;
            rd_act_q    <= 1'b1;
            rd_arm_q    <= 1'b0;
            rd_addr_q   <= 2'd0;
            led_q       <= 8'h00;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_udf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
        end else begin
            wr_act_q    <= wr_act_d;
            rd_act_q    <= rd_act_d;
            rd_arm_q    <= rd_arm_d;
            rd_addr_q   <= rd_addr_d;
            led_q       <= led_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_udf_q    <= rx_udf_d;
            rx_ovf_q    <= rx_ovf_d;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // FIFO storage needs no reset; empty FIFOs never expose it
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            tx_mem_q[i] <= tx_mem_d[i];
            rx_mem_q[i] <= rx_mem_d[i];
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: queue-based reference model, directed scenarios then
// randomized port-bus traffic with random TX consumer / RX producer activity.
module tb_io_port_unit;

    localparam int D = 4;
    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [1:0] IOAD = 2'd0;
    wire  [7:0] IODB;
    logic       nPREQ = 1'b1, nPRD = 1'b1, nPWR = 1'b1;
    logic [7:0] sw_in = 8'h00;
    logic [7:0] led_out, tx_data;
    logic       tx_valid, rx_ready;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
`ifdef IO_IRQ_EN
    logic       nIRQ;
`endif

    logic [7:0] tb_db = 8'h00;
    logic       tb_db_en = 1'b0;
    assign IODB = tb_db_en ? tb_db : 8'bz;

    io_port_unit #(.FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .IOAD     (IOAD),
        .IODB     (IODB),
        .nPREQ    (nPREQ),
        .nPRD     (nPRD),
        .nPWR     (nPWR),
        .sw_in    (sw_in),
        .led_out  (led_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`ifdef IO_IRQ_EN
        .nIRQ     (nIRQ),
`endif
        .rx_ready (rx_ready)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0] tx_m[$], rx_m[$], sw_hist[$];
    logic [7:0] tx_exp_q[$], rd_exp_q[$];
    logic [7:0] led_m = 8'h00;
    bit tx_ovf_m, rx_udf_m, rx_ovf_m;
    bit irq_n_m = 1'b1;

    // Per-cycle events announced by the stimulus tasks
    bit ev_wr, ev_rd_end, rand_bg, rx_hold_off, rd_probe;
    logic [1:0] ev_rd_addr;
    bit mon_en, final_req, final_done;

    int n_pass = 0, n_total = 0, n_timeout = 0;

    function automatic logic [7:0] model_read(input logic [1:0] a);
        logic [7:0] v;
        case (a)
            2'd0: v = sw_hist[0];
            2'd1: v = (rx_m.size() != 0) ? rx_m[0] : 8'h00;
            2'd2: begin
                v = 8'h00;
                v[0] = (tx_m.size() == 0);
                v[1] = (tx_m.size() == D);
                v[2] = (rx_m.size() == 0);
                v[3] = (rx_m.size() == D);
`ifdef IO_IRQ_EN
                v[7] = !irq_n_m;
`endif
            end
            default: v = {5'b00000, rx_ovf_m, rx_udf_m, tx_ovf_m};
        endcase
        return v;
    endfunction

    // Applies the effect of the coming clock edge using the state before that edge.
    task automatic model_step();
        bit irq_next, tx_full_m, tx_pop_m, rx_full_m, rx_under;
        if (!nRST) begin
            tx_m.delete(); rx_m.delete(); tx_exp_q.delete(); sw_hist.delete();
            repeat (S) sw_hist.push_back(8'h00);
            led_m = 8'h00; tx_ovf_m = 0; rx_udf_m = 0; rx_ovf_m = 0; irq_n_m = 1;
            return;
        end
        irq_next  = !((rx_m.size() != 0) || tx_ovf_m || rx_ovf_m);
        tx_full_m = (tx_m.size() == D);
        tx_pop_m  = (tx_m.size() != 0) && tx_ready;
        rx_full_m = (rx_m.size() == D);
        rx_under  = ev_rd_end && ev_rd_addr == 2'd1 && rx_m.size() == 0;
        if (tx_pop_m) void'(tx_m.pop_front());
        if (ev_wr && IOAD == 2'd1 && !tx_full_m) begin
            tx_m.push_back(tb_db);
            tx_exp_q.push_back(tb_db);
        end
        if (ev_rd_end && ev_rd_addr == 2'd1 && !rx_under) void'(rx_m.pop_front());
        if (rx_valid && !rx_full_m) rx_m.push_back(rx_data);
        if (ev_wr && IOAD == 2'd3) begin
            if (tb_db[0]) tx_ovf_m = 0;
            if (tb_db[1]) rx_udf_m = 0;
            if (tb_db[2]) rx_ovf_m = 0;
        end
        if (ev_wr && IOAD == 2'd1 && tx_full_m) tx_ovf_m = 1;
        if (rx_under) rx_udf_m = 1;
        if (rx_valid && rx_full_m) rx_ovf_m = 1;
        if (ev_wr && IOAD == 2'd0) led_m = tb_db;
        sw_hist.push_back(sw_in);
        void'(sw_hist.pop_front());
        irq_n_m = irq_next;
    endtask

    task automatic tick();
        if (rand_bg) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom);
        end
        if (rx_hold_off) rx_valid = 1'b0;
        @(negedge CLK);
        #1;
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        nPREQ = 0; nPWR = 0; IOAD = a; tb_db = d; tb_db_en = 1;
        ev_wr = 1;
        tick();
        ev_wr = 0;
        repeat (hold - 1) tick();
        nPREQ = 1; nPWR = 1; tb_db_en = 0;
        tick();
    endtask

    task automatic do_read(input logic [1:0] a, input bit use_const, input logic [7:0] cval);
        nPREQ = 0; nPRD = 0; IOAD = a;
        rx_hold_off = (a == 2'd1) && (rx_m.size() == 0);
        rd_exp_q.push_back(use_const ? cval : model_read(a));
        rd_probe = 1;
        tick();
        rd_probe = 0; rx_hold_off = 0;
        nPREQ = 1; nPRD = 1;
        ev_rd_end = 1; ev_rd_addr = a;
        tick();
        ev_rd_end = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares DUT outputs against the model state before the coming edge
    always @(negedge CLK) begin
        if (mon_en) begin
            check("tx_valid", 32'(tx_valid), 32'(tx_m.size() != 0));
            check("rx_ready", 32'(rx_ready), 32'(rx_m.size() != D));
            check("led_out", 32'(led_out), 32'(led_m));
            check("tx_data", 32'(tx_data), 32'((tx_m.size() != 0) ? tx_m[0] : 8'h00));
`ifdef IO_IRQ_EN
            check("nIRQ", 32'(nIRQ), 32'(irq_n_m));
`endif
            if (tx_valid && tx_ready) begin
                check("tx_expected", 32'(tx_exp_q.size() != 0), 32'd1);
                if (tx_exp_q.size() != 0) check("tx_stream", 32'(tx_data), 32'(tx_exp_q.pop_front()));
            end
            if (rd_probe) begin
                check("rd_expected", 32'(rd_exp_q.size() != 0), 32'd1);
                if (rd_exp_q.size() != 0) check("rd_data", 32'(IODB), 32'(rd_exp_q.pop_front()));
            end
        end
        if (final_req && !final_done) begin
            check("tx_drained", 32'(tx_exp_q.size()), 32'd0);
            check("rd_drained", 32'(rd_exp_q.size()), 32'd0);
            final_done = 1;
        end
    end

    logic [7:0] st_full;
    logic [1:0] ra;
    int op;

    initial begin
        // Reset and initial status
        @(posedge CLK); #1;
        tick();
        nRST = 1;
        mon_en = 1;
        do_read(2'd2, 1, 8'h05);

        // LED write with held strobe, then synchronized switch read
        do_write(2'd0, 8'h7F, 3);
        sw_in = 8'hA7;
        repeat (S) tick();
        do_read(2'd0, 1, 8'hA7);

        // TX overflow then drain
        tx_ready = 0;
        for (int i = 1; i <= D + 1; i++) do_write(2'd1, 8'(i), 1);
`ifdef IO_IRQ_EN
        st_full = 8'h86;
`else
        st_full = 8'h06;
`endif
        do_read(2'd2, 1, st_full);
        do_read(2'd3, 1, 8'h01);
        tx_ready = 1;
        repeat (D + 2) tick();
        do_write(2'd3, 8'h01, 1);

        // RX bytes, reads, underflow
        rx_valid = 1; rx_data = 8'h3C; tick();
        rx_data = 8'h5A; tick();
        rx_valid = 0;
        do_read(2'd1, 1, 8'h3C);
        do_read(2'd1, 1, 8'h5A);
        do_read(2'd1, 1, 8'h00);
        do_read(2'd3, 1, 8'h02);
        do_write(2'd3, 8'h02, 1);

        // RX overflow while flags are cleared: set wins
        rx_valid = 1;
        for (int i = 0; i <= D; i++) begin rx_data = 8'(8'h90 + i); tick(); end
        do_write(2'd3, 8'h07, 1);
        rx_valid = 0;
        do_read(2'd3, 1, 8'h04);
        for (int i = 0; i < D; i++) do_read(2'd1, 1, 8'(8'h90 + i));
        do_write(2'd3, 8'h07, 1);
        do_read(2'd3, 1, 8'h00);

        // Reset asserted during a held write strobe: no write after release
        nPREQ = 0; nPWR = 0; IOAD = 2'd0; tb_db = 8'hEE; tb_db_en = 1; nRST = 0;
        tick();
        nRST = 1;
        repeat (2) tick();
        nPREQ = 1; nPWR = 1; tb_db_en = 0;
        tick();
        do_read(2'd2, 1, 8'h05);

        // Randomized traffic
        rand_bg = 1;
        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 9);
            ra = 2'($urandom_range(0, 3));
            if (op < 4) do_write(ra, 8'($urandom), $urandom_range(1, 3));
            else if (op < 8) do_read(ra, 0, 8'h00);
            else tick();
        end
        rand_bg = 0;
        rx_valid = 0; tx_ready = 1;
        repeat (D + 3) tick();

        final_req = 1;
        for (int i = 0; i < 5 && !final_done; i++) tick();
        if (!final_done) begin
            $display("FAIL final_check: monitor did not complete expected 1 got 0");
            n_timeout++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total + n_timeout);
        $finish;
    end

endmodule
